// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sits between the MEM stage and the multi-cycle data RAM. It takes one load
// or store per transaction, drives the RAM cs/we handshake, and does a
// read-modify-write for byte and halfword stores. Load data is returned
// sign- or zero-extended. Misaligned accesses and RAM timeouts return an error.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake (req_ready high only in IDLE)
//   req_we              1 = store, 0 = load
//   req_size            0 byte, 1 halfword, 2/3 word
//   req_signed          load extension: 1 sign, 0 zero
//   req_addr            byte address
//   req_wdata           store data, right-aligned
//   resp_valid          one-cycle completion pulse
//   resp_rdata          load result (0 for stores and errors)
//   resp_err            error flag, qualified by resp_valid
//   mem_cs/mem_we       RAM chip select / write enable
//   mem_addr            RAM word address
//   mem_din/mem_dout    RAM write / read data
//   mem_stall           RAM busy
//
// state | meaning
// IDLE  | ready for a request
// RD    | RAM read in progress (load, or first half of a sub-word store)
// MERGE | cs low for one cycle, merged word presented on mem_din
// WR    | RAM write in progress
// RESP  | resp_valid pulse, then back to IDLE

module mem_access_ctrl #(
   parameter int TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_cs,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout,
   input  logic        mem_stall
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_MERGE,
      S_WR,
      S_RESP
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;

   logic        r_we, w_we_nxt;
   logic [1:0]  r_size, w_size_nxt;
   logic        r_signed, w_signed_nxt;
   logic [1:0]  r_lane, w_lane_nxt;
   logic [31:0] r_wdata, w_wdata_nxt;

   logic        r_req_ready, w_req_ready_nxt;
   logic        r_resp_valid, w_resp_valid_nxt;
   logic [31:0] r_resp_rdata, w_resp_rdata_nxt;
   logic        r_resp_err, w_resp_err_nxt;
   logic        r_mem_cs, w_mem_cs_nxt;
   logic        r_mem_we, w_mem_we_nxt;
   logic [31:0] r_mem_addr, w_mem_addr_nxt;
   logic [31:0] r_mem_din, w_mem_din_nxt;

   logic        w_accept;
   logic        w_misaligned;
   logic        w_timeout;
   logic [31:0] w_shift;
   logic [31:0] w_load_data;
   logic [31:0] w_merged;

   assign w_accept     = (r_state == S_IDLE) && r_req_ready && req_valid;
   assign w_misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                         (req_size[1] && (req_addr[1:0] != 2'b00));
   // Terminal count: this stalled cycle is the TIMEOUT-th one.
   assign w_timeout    = mem_stall && (r_cnt == CW'(TIMEOUT - 1));

   // Aligned halfwords have lane[0]=0, so one byte-granular shift covers both.
   assign w_shift = mem_dout >> {r_lane, 3'b000};

   always_comb begin
      w_load_data = mem_dout;
      case (r_size)
         2'd0:    w_load_data = {{24{r_signed & w_shift[7]}},  w_shift[7:0]};
         2'd1:    w_load_data = {{16{r_signed & w_shift[15]}}, w_shift[15:0]};
         default: w_load_data = mem_dout;
      endcase
   end

   always_comb begin
      w_merged = mem_dout;
      case (r_size)
         2'd0:    w_merged[{r_lane, 3'b000} +: 8]      = r_wdata[7:0];
         2'd1:    w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
         default: w_merged = r_wdata;
      endcase
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_we_nxt         = r_we;
      w_size_nxt       = r_size;
      w_signed_nxt     = r_signed;
      w_lane_nxt       = r_lane;
      w_wdata_nxt      = r_wdata;
      w_resp_rdata_nxt = r_resp_rdata;
      w_resp_err_nxt   = r_resp_err;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_din_nxt    = r_mem_din;

      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_we_nxt         = req_we;
               w_size_nxt       = req_size;
               w_signed_nxt     = req_signed;
               w_lane_nxt       = req_addr[1:0];
               w_wdata_nxt      = req_wdata;
               w_mem_addr_nxt   = {2'b00, req_addr[31:2]};
               w_resp_rdata_nxt = '0;
               w_resp_err_nxt   = 1'b0;
               if (w_misaligned) begin
                  w_resp_err_nxt = 1'b1;
                  w_state_nxt    = S_RESP;
               end else if (req_we && req_size[1]) begin
                  w_mem_din_nxt = req_wdata;
                  w_state_nxt   = S_WR;
               end else begin
                  w_state_nxt = S_RD;
               end
            end
         end
         S_RD: begin
            if (!mem_stall) begin
               if (r_we) begin
                  w_mem_din_nxt = w_merged;
                  w_state_nxt   = S_MERGE;
               end else begin
                  w_resp_rdata_nxt = w_load_data;
                  w_state_nxt      = S_RESP;
               end
            end else if (w_timeout) begin
               w_resp_err_nxt   = 1'b1;
               w_resp_rdata_nxt = '0;
               w_state_nxt      = S_RESP;
            end
         end
         S_MERGE: begin
            w_state_nxt = S_WR;
         end
         S_WR: begin
            if (!mem_stall) begin
               w_state_nxt = S_RESP;
            end else if (w_timeout) begin
               w_resp_err_nxt = 1'b1;
               w_state_nxt    = S_RESP;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      w_req_ready_nxt  = (w_state_nxt == S_IDLE);
      w_resp_valid_nxt = (w_state_nxt == S_RESP);
      w_mem_cs_nxt     = (w_state_nxt == S_RD) || (w_state_nxt == S_WR);
      w_mem_we_nxt     = (w_state_nxt == S_WR);

      w_cnt_nxt = r_cnt;
      if (w_state_nxt != r_state) begin
         w_cnt_nxt = '0;
      end else if (((r_state == S_RD) || (r_state == S_WR)) && mem_stall) begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_size       <= 2'd0;
         r_signed     <= 1'b0;
         r_lane       <= 2'd0;
         r_wdata      <= '0;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_mem_cs     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_din    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_we         <= w_we_nxt;
         r_size       <= w_size_nxt;
         r_signed     <= w_signed_nxt;
         r_lane       <= w_lane_nxt;
         r_wdata      <= w_wdata_nxt;
         r_req_ready  <= w_req_ready_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_resp_err   <= w_resp_err_nxt;
         r_mem_cs     <= w_mem_cs_nxt;
         r_mem_we     <= w_mem_we_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_din    <= w_mem_din_nxt;
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign mem_cs     = r_mem_cs;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_din    = r_mem_din;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

   localparam int D    = 8;
   localparam int TOUT = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_cs;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        mem_stall;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } resp_t;
   resp_t exp_q[$];

   // RAM model: cs must be held D+1 cycles; stall drops in the last one.
   logic [31:0] ram [16];
   int          ram_cnt = 0;
   bit          stall_forever = 1'b0;
   bit          ram_init = 1'b0;

   assign mem_stall = mem_cs && (stall_forever || (ram_cnt < D));
   assign mem_dout  = ram[mem_addr[3:0]];

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 16; i++) ram[i] <= 32'h0101_0101 * i;
         ram[3] <= 32'hDEAD_BEEF;
         ram_cnt <= 0;
      end else if (mem_cs && !mem_stall) begin
         if (mem_we) ram[mem_addr[3:0]] <= mem_din;
         ram_cnt <= 0;
      end else if (mem_cs) begin
         ram_cnt <= ram_cnt + 1;
      end else begin
         ram_cnt <= 0;
      end
   end

   always #5 clk = ~clk;

   mem_access_ctrl #(.TIMEOUT(TOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_cs     (mem_cs),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .mem_stall  (mem_stall)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Runs one transaction. lat counts edges with the accepting edge as 1.
   task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          output int lat, output int cs_hi, output int rises,
                          output int low_between, output logic [31:0] seen_addr);
      resp_t e;
      resp_t got;
      logic  prev_cs;
      @(negedge clk);
      chk({tag, "_ready_idle"}, {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      e.err   = exp_err;
      e.rdata = exp_rdata;
      exp_q.push_back(e);
      @(posedge clk); #1;
      chk({tag, "_ready_busy"}, {31'b0, req_ready}, 32'd0);
      // Garbage request held while busy; it must be ignored.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'd2;
      req_addr  = 32'h0000_0003;
      req_wdata = 32'h0;
      lat = 1; cs_hi = 0; rises = 0; low_between = 0; prev_cs = 1'b0; seen_addr = '0;
      while (!resp_valid && lat < 200) begin
         if (mem_cs) begin
            cs_hi++;
            seen_addr = mem_addr;
            if (!prev_cs) rises++;
         end else if (rises > 0) begin
            low_between++;
         end
         prev_cs = mem_cs;
         @(posedge clk); #1;
         lat++;
      end
      req_valid = 1'b0;
      chk({tag, "_resp_seen"}, {31'b0, resp_valid}, 32'd1);
      if (resp_valid) begin
         chk({tag, "_q_nonempty"}, {31'b0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            chk({tag, "_err"},   {31'b0, resp_err}, {31'b0, got.err});
            chk({tag, "_rdata"}, resp_rdata, got.rdata);
         end
         chk({tag, "_cs_in_resp"}, {31'b0, mem_cs}, 32'd0);
      end
      @(posedge clk); #1;
      chk({tag, "_pulse_end"}, {31'b0, resp_valid}, 32'd0);
      chk({tag, "_ready_back"}, {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      int lat, cs_hi, rises, lowb, bad;
      logic [31:0] sa;

      ram_init = 1'b1;
      repeat (3) @(negedge clk);
      ram_init = 1'b0;
      #1;
      chk("rst_ready",  {31'b0, req_ready},  32'd0);
      chk("rst_valid",  {31'b0, resp_valid}, 32'd0);
      chk("rst_cs",     {31'b0, mem_cs},     32'd0);
      chk("rst_addr",   mem_addr,            32'd0);
      chk("rst_rdata",  resp_rdata,          32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rel_ready", {31'b0, req_ready}, 32'd1);

      // Word load at 0x0C
      run_req("lw", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 1'b0, 32'hDEAD_BEEF, lat, cs_hi, rises, lowb, sa);
      chk("lw_lat",   lat,   32'd10);
      chk("lw_cs_hi", cs_hi, 32'd9);
      chk("lw_addr",  sa,    32'd3);

      run_req("lb",  1'b0, 2'd0, 1'b1, 32'h0F, 32'h0, 1'b0, 32'hFFFF_FFDE, lat, cs_hi, rises, lowb, sa);
      chk("lb_lat", lat, 32'd10);
      run_req("lbu", 1'b0, 2'd0, 1'b0, 32'h0F, 32'h0, 1'b0, 32'h0000_00DE, lat, cs_hi, rises, lowb, sa);
      run_req("lh",  1'b0, 2'd1, 1'b1, 32'h0E, 32'h0, 1'b0, 32'hFFFF_DEAD, lat, cs_hi, rises, lowb, sa);
      run_req("lhu", 1'b0, 2'd1, 1'b0, 32'h0C, 32'h0, 1'b0, 32'h0000_BEEF, lat, cs_hi, rises, lowb, sa);
      run_req("lb0", 1'b0, 2'd0, 1'b1, 32'h0C, 32'h0, 1'b0, 32'hFFFF_FFEF, lat, cs_hi, rises, lowb, sa);
      run_req("lw3", 1'b0, 2'd3, 1'b0, 32'h14, 32'h0, 1'b0, 32'h0505_0505, lat, cs_hi, rises, lowb, sa);

      // Byte store: read, one-cycle cs gap, write
      run_req("sb", 1'b1, 2'd0, 1'b0, 32'h0D, 32'hFFFF_FF55, 1'b0, 32'h0, lat, cs_hi, rises, lowb, sa);
      chk("sb_rises", rises, 32'd2);
      chk("sb_gap",   lowb,  32'd1);
      chk("sb_cs_hi", cs_hi, 32'd18);
      chk("sb_ram",   ram[3], 32'hDEAD_55EF);

      run_req("sh", 1'b1, 2'd1, 1'b0, 32'h0E, 32'hABCD_1234, 1'b0, 32'h0, lat, cs_hi, rises, lowb, sa);
      chk("sh_ram",  ram[3], 32'h1234_55EF);
      chk("sh_gap",  lowb,   32'd1);

      // Misaligned requests: error after one edge, no RAM access
      run_req("sw_mis", 1'b1, 2'd2, 1'b0, 32'h02, 32'h1111_1111, 1'b1, 32'h0, lat, cs_hi, rises, lowb, sa);
      chk("sw_mis_lat",   lat,    32'd1);
      chk("sw_mis_rises", rises,  32'd0);
      chk("sw_mis_ram",   ram[0], 32'h0);
      run_req("lh_mis", 1'b0, 2'd1, 1'b1, 32'h01, 32'h0, 1'b1, 32'h0, lat, cs_hi, rises, lowb, sa);
      chk("lh_mis_lat", lat, 32'd1);
      run_req("s3_mis", 1'b0, 2'd3, 1'b0, 32'h02, 32'h0, 1'b1, 32'h0, lat, cs_hi, rises, lowb, sa);
      chk("s3_mis_rises", rises, 32'd0);

      // Word store
      run_req("sw", 1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, 1'b0, 32'h0, lat, cs_hi, rises, lowb, sa);
      chk("sw_lat",   lat,    32'd10);
      chk("sw_rises", rises,  32'd1);
      chk("sw_ram",   ram[4], 32'hCAFE_F00D);

      // Timeout on a permanently stalled RAM
      stall_forever = 1'b1;
      run_req("tmo", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, 1'b1, 32'h0, lat, cs_hi, rises, lowb, sa);
      chk("tmo_cs_hi", cs_hi, TOUT);
      chk("tmo_rises", rises, 32'd1);
      stall_forever = 1'b0;
      run_req("post_tmo", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFE_F00D, lat, cs_hi, rises, lowb, sa);
      chk("post_tmo_lat", lat, 32'd10);

      // Reset during the read phase of a halfword store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
      req_addr = 32'h0E; req_wdata = 32'h0000_9999;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("rstmid_cs_before", {31'b0, mem_cs}, 32'd1);
      rst = 1'b0;
      #1;
      chk("rstmid_cs",    {31'b0, mem_cs},    32'd0);
      chk("rstmid_ready", {31'b0, req_ready}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rstmid_ready_rel", {31'b0, req_ready}, 32'd1);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         if (resp_valid || mem_cs) bad++;
         @(posedge clk); #1;
      end
      chk("rstmid_quiet", bad, 32'd0);
      chk("rstmid_ram",   ram[3], 32'h1234_55EF);
      chk("q_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
